// File: rtl/bp_pkg.sv
// Shared types and default sizing for the branch predictor update scheduler.
// Optional hit counter is enabled by defining BP_HIT_COUNT_EN.
package bp_pkg;

   localparam int unsigned BP_DEPTH  = 4;
   localparam int unsigned BP_ADDR_W = 3;
   localparam int unsigned BP_CNT_W  = 16;

   // One in-flight lookup at the default address width
   typedef struct packed {
      logic [BP_ADDR_W-1:0] addr;
      logic                 pred;
   } bp_entry_t;

   typedef enum logic {
      ST_RUN   = 1'b0,
      ST_FLUSH = 1'b1
   } bp_state_e;

endpackage

// File: rtl/bp_inflight_fifo.sv
// In-order queue of outstanding branch lookups with separate occupancy count
// and a synchronous clear that dominates any same-cycle push or pop.
module bp_inflight_fifo
   import bp_pkg::*;
#(
   parameter int unsigned DEPTH   = BP_DEPTH,
   parameter type         entry_t = bp_entry_t
) (
   input  logic                   clk_i,
   input  logic                   rst_i,
   input  logic                   clr_i,
   input  logic                   push_i,
   input  logic                   pop_i,
   input  entry_t                 push_data_i,
   output entry_t                 head_o,
   output logic [$clog2(DEPTH):0] occ_o
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
   localparam logic [PTR_W:0]   OCC_ONE = (PTR_W + 1)'(1);

   entry_t           mem_q [DEPTH];
   logic [PTR_W-1:0] head_q;
   logic [PTR_W-1:0] tail_q;
   logic [PTR_W:0]   occ_q;

   // Entry storage; slots outside the live window are don't-care, so no reset
   always_ff @(posedge clk_i) begin
      if (push_i) begin
         mem_q[tail_q] <= push_data_i;
      end
   end

   // Pointers wrap for free because DEPTH is a power of two
   always_ff @(posedge clk_i) begin
      if (rst_i || clr_i) begin
         head_q <= '0;
         tail_q <= '0;
         occ_q  <= '0;
      end else begin
         if (push_i) begin
            tail_q <= tail_q + PTR_ONE;
         end
         if (pop_i) begin
            head_q <= head_q + PTR_ONE;
         end
         case ({push_i, pop_i})
            2'b10:   occ_q <= occ_q + OCC_ONE;
            2'b01:   occ_q <= occ_q - OCC_ONE;
            default: occ_q <= occ_q;
         endcase
      end
   end

   assign head_o = mem_q[head_q];
   assign occ_o  = occ_q;

endmodule

// File: rtl/bp_update_scheduler.sv
// Branch predictor update scheduler: tracks in-flight lookups, issues one
// table write per resolved branch, flushes on misprediction, counts misses.
// Define BP_HIT_COUNT_EN to add the saturating HITS output.
module bp_update_scheduler
   import bp_pkg::*;
#(
   parameter int unsigned DEPTH  = BP_DEPTH,
   parameter int unsigned ADDR_W = BP_ADDR_W,
   parameter int unsigned CNT_W  = BP_CNT_W
) (
   input  logic                   CLOCK,
   input  logic                   INIT,
   input  logic                   LOOKUP_VALID,
   input  logic [ADDR_W-1:0]      LOOKUP_ADDR,
   input  logic                   PRED_IN,
   output logic                   LOOKUP_READY,
   input  logic                   RESOLVE_VALID,
   input  logic                   RESOLVE_OUTCOME,
   output logic                   UPD_VALID,
   output logic [ADDR_W-1:0]      UPD_ADDR,
   output logic                   UPD_OUTCOME,
   output logic                   FLUSH,
   output logic [CNT_W-1:0]       MISSES,
`ifdef BP_HIT_COUNT_EN
   output logic [CNT_W-1:0]       HITS,
`endif
   output logic [$clog2(DEPTH):0] OCCUPANCY
);

   localparam int unsigned OCC_W = $clog2(DEPTH) + 1;
   localparam logic [OCC_W-1:0] OCC_FULL = OCC_W'(DEPTH);
   localparam logic [OCC_W-1:0] OCC_ONE  = OCC_W'(1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   // Same layout as bp_entry_t, resized to this instance's address width
   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      logic              pred;
   } sched_entry_t;

   bp_state_e         state_q, state_d;
   logic              ready_q, ready_d;
   logic              upd_valid_q, upd_valid_d;
   logic [ADDR_W-1:0] upd_addr_q, upd_addr_d;
   logic              upd_outcome_q, upd_outcome_d;
   logic              flush_q, flush_d;
   logic [CNT_W-1:0]  misses_q, misses_d;
`ifdef BP_HIT_COUNT_EN
   logic [CNT_W-1:0]  hits_q, hits_d;
`endif

   sched_entry_t      push_entry;
   sched_entry_t      head;
   logic [OCC_W-1:0]  occ;
   logic [OCC_W-1:0]  occ_next;
   logic              push;
   logic              pop;
   logic              miss;

   bp_inflight_fifo #(
      .DEPTH   (DEPTH),
      .entry_t (sched_entry_t)
   ) u_fifo (
      .clk_i       (CLOCK),
      .rst_i       (INIT),
      .clr_i       (miss),
      .push_i      (push),
      .pop_i       (pop),
      .push_data_i (push_entry),
      .head_o      (head),
      .occ_o       (occ)
   );

   // Accept/resolve decisions and next values of every registered output;
   // ready is precomputed from next occupancy so it can be a flop
   always_comb begin
      push       = LOOKUP_VALID && ready_q;
      pop        = RESOLVE_VALID && (state_q == ST_RUN) && (occ != '0);
      miss       = pop && (head.pred != RESOLVE_OUTCOME);
      push_entry = '{addr: LOOKUP_ADDR, pred: PRED_IN};

      occ_next = occ;
      if (miss) begin
         occ_next = '0;
      end else if (push && !pop) begin
         occ_next = occ + OCC_ONE;
      end else if (pop && !push) begin
         occ_next = occ - OCC_ONE;
      end

      state_d       = miss ? ST_FLUSH : ST_RUN;
      ready_d       = (state_d == ST_RUN) && (occ_next < OCC_FULL);
      upd_valid_d   = pop;
      upd_addr_d    = pop ? head.addr : upd_addr_q;
      upd_outcome_d = pop ? RESOLVE_OUTCOME : upd_outcome_q;
      flush_d       = miss;
      misses_d      = (miss && (misses_q != '1)) ? misses_q + CNT_ONE : misses_q;
`ifdef BP_HIT_COUNT_EN
      hits_d        = (pop && !miss && (hits_q != '1)) ? hits_q + CNT_ONE : hits_q;
`endif
   end

   // FSM and registered outputs
   always_ff @(posedge CLOCK) begin
      if (INIT) begin
         state_q       <= ST_RUN;
         ready_q       <= 1'b0;
         upd_valid_q   <= 1'b0;
         upd_addr_q    <= '0;
         upd_outcome_q <= 1'b0;
         flush_q       <= 1'b0;
         misses_q      <= '0;
`ifdef BP_HIT_COUNT_EN
         hits_q        <= '0;
`endif
      end else begin
         state_q       <= state_d;
         ready_q       <= ready_d;
         upd_valid_q   <= upd_valid_d;
         upd_addr_q    <= upd_addr_d;
         upd_outcome_q <= upd_outcome_d;
         flush_q       <= flush_d;
         misses_q      <= misses_d;
`ifdef BP_HIT_COUNT_EN
         hits_q        <= hits_d;
`endif
      end
   end

   assign LOOKUP_READY = ready_q;
   assign UPD_VALID    = upd_valid_q;
   assign UPD_ADDR     = upd_addr_q;
   assign UPD_OUTCOME  = upd_outcome_q;
   assign FLUSH        = flush_q;
   assign MISSES       = misses_q;
   assign OCCUPANCY    = occ;
`ifdef BP_HIT_COUNT_EN
   assign HITS         = hits_q;
`endif

endmodule
